// File: rtl/sys_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sys_bus_ctrl
//   CPU-side bus controller. A single valid/ready master request is decoded
//   against NSLAVE address windows (addr[31:24] prefix/mask), the request is
//   latched and broadcast to the slaves, and the selected slave is given a
//   one-hot s_valid for the whole access phase. Slaves are either
//   fixed-latency (wait-state count) or handshaking (own s_ready, marked by a
//   wait value of 4'hF). Hung accesses are aborted by a timeout. Misses and
//   timeouts return DEFAULT_DATA with m_err and are logged.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   m_addr/m_wdata      master byte address / write data
//   m_lane/m_wr         master byte enables / direction (1 = write)
//   m_valid             master request, held until m_ready
//   m_rdata/m_ready     read data / one-cycle completion strobe
//   m_err               error flag qualifying m_ready
//   s_valid             one-hot slave select during the access phase
//   s_addr/s_wdata      latched address / write data (broadcast)
//   s_lane/s_wr         latched byte enables / direction (broadcast)
//   s_rdata             packed slave read data (slave i at [32i+31:32i])
//   s_ready             per-slave completion (handshake slaves only)
//   err_addr            address of the most recent errored access
//   err_count           errored-access count, saturating at 255
// ---------------------------------------------------------------------------
module sys_bus_ctrl #(
    parameter int                    NSLAVE       = 4,
    parameter logic [8*NSLAVE-1:0]   SLAVE_BASE   = {8'h14, 8'h13, 8'h11, 8'h00},
    parameter logic [8*NSLAVE-1:0]   SLAVE_MASK   = {8'hFF, 8'hFF, 8'hFF, 8'hF0},
    parameter logic [4*NSLAVE-1:0]   SLAVE_WAIT   = {4'd0, 4'd0, 4'hF, 4'd0},
    parameter int                    TIMEOUT      = 255,
    parameter logic [31:0]           DEFAULT_DATA = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_lane,
    input  logic                   m_wr,
    input  logic                   m_valid,
    output logic [31:0]            m_rdata,
    output logic                   m_ready,
    output logic                   m_err,
    output logic [NSLAVE-1:0]      s_valid,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_lane,
    output logic                   s_wr,
    input  logic [NSLAVE*32-1:0]   s_rdata,
    input  logic [NSLAVE-1:0]      s_ready,
    output logic [31:0]            err_addr,
    output logic [7:0]             err_count
);

    localparam int          SEL_W   = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
    localparam int          PW      = 8;    // prefix/mask field width
    localparam int          WW      = 4;    // wait field width
    localparam int          DW      = 32;   // data width per slave
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [SEL_W-1:0]    sel_q,       sel_d;
    logic [15:0]         acc_cnt_q,   acc_cnt_d;
    logic                post_done_q, post_done_d;
    logic [31:0]         m_rdata_q,   m_rdata_d;
    logic                m_ready_q,   m_ready_d;
    logic                m_err_q,     m_err_d;
    logic [NSLAVE-1:0]   s_valid_q,   s_valid_d;
    logic [31:0]         s_addr_q,    s_addr_d;
    logic [31:0]         s_wdata_q,   s_wdata_d;
    logic [3:0]          s_lane_q,    s_lane_d;
    logic                s_wr_q,      s_wr_d;
    logic [31:0]         err_addr_q,  err_addr_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                hit_s;
    logic [SEL_W-1:0]    hit_idx_s;
    logic [3:0]          sel_wait_s;
    logic [31:0]         sel_rdata_s;
    logic                sel_ready_s;
    logic                is_hs_s;
    logic                complete_s;
    logic                timeout_s;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Address decode; scanning from the top down lets the lowest index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((m_addr[31:24] & SLAVE_MASK[i*PW +: PW]) ==
                (SLAVE_BASE[i*PW +: PW] & SLAVE_MASK[i*PW +: PW])) begin
                hit_s     = 1'b1;
                hit_idx_s = SEL_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Attributes and responses of the slave latched for the current access.
    always_comb begin
        sel_wait_s  = 4'd0;
        sel_rdata_s = 32'd0;
        sel_ready_s = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_wait_s  = SLAVE_WAIT[i*WW +: WW];
                sel_rdata_s = s_rdata[i*DW +: DW];
                sel_ready_s = s_ready[i];
            end else begin
                sel_wait_s  = sel_wait_s;
                sel_rdata_s = sel_rdata_s;
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // Access completion and timeout detection. acc_cnt_q holds the number of
    // access cycles already spent, so cycle t of the access sees t-1.
    always_comb begin
        is_hs_s = (sel_wait_s == 4'hF);
        if (is_hs_s) begin
            complete_s = sel_ready_s;
        end else begin
            complete_s = (acc_cnt_q == {12'd0, sel_wait_s});
        end
        timeout_s = (acc_cnt_q == TO_LAST);
    end

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        acc_cnt_d   = acc_cnt_q;
        post_done_d = 1'b0;
        m_rdata_d   = m_rdata_q;
        m_ready_d   = 1'b0;
        m_err_d     = m_err_q;
        s_valid_d   = s_valid_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_lane_d    = s_lane_q;
        s_wr_d      = s_wr_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                s_valid_d = '0;
                // The cycle right after DONE ignores m_valid: a master that
                // reacts to m_ready one cycle late is still showing the
                // request that has just finished.
                if (m_valid && !post_done_q) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_lane_d  = m_lane;
                    s_wr_d    = m_wr;
                    sel_d     = hit_idx_s;
                    acc_cnt_d = 16'd0;
                    if (hit_s) begin
                        state_d   = ST_ACCESS;
                        s_valid_d = NSLAVE'(1'b1) << hit_idx_s;
                    end else begin
                        state_d     = ST_DONE;
                        m_ready_d   = 1'b1;
                        m_err_d     = 1'b1;
                        m_rdata_d   = DEFAULT_DATA;
                        err_addr_d  = m_addr;
                        err_count_d = sat_inc8(err_count_q);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // Completion is checked first so that a slave finishing in
                // the timeout cycle still completes without error.
                if (complete_s) begin
                    state_d   = ST_DONE;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b0;
                    m_rdata_d = sel_rdata_s;
                    s_valid_d = '0;
                end else if (timeout_s) begin
                    state_d     = ST_DONE;
                    m_ready_d   = 1'b1;
                    m_err_d     = 1'b1;
                    m_rdata_d   = DEFAULT_DATA;
                    s_valid_d   = '0;
                    err_addr_d  = s_addr_q;
                    err_count_d = sat_inc8(err_count_q);
                end else begin
                    acc_cnt_d = acc_cnt_q + 16'd1;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                post_done_d = 1'b1;
                s_valid_d   = '0;
            end

            default: begin
                state_d   = ST_IDLE;
                s_valid_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            acc_cnt_q   <= 16'd0;
            post_done_q <= 1'b0;
            m_rdata_q   <= 32'd0;
            m_ready_q   <= 1'b0;
            m_err_q     <= 1'b0;
            s_valid_q   <= '0;
            s_addr_q    <= 32'd0;
            s_wdata_q   <= 32'd0;
            s_lane_q    <= 4'd0;
            s_wr_q      <= 1'b0;
            err_addr_q  <= 32'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            acc_cnt_q   <= acc_cnt_d;
            post_done_q <= post_done_d;
            m_rdata_q   <= m_rdata_d;
            m_ready_q   <= m_ready_d;
            m_err_q     <= m_err_d;
            s_valid_q   <= s_valid_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_lane_q    <= s_lane_d;
            s_wr_q      <= s_wr_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_rdata   = m_rdata_q;
    assign m_ready   = m_ready_q;
    assign m_err     = m_err_q;
    assign s_valid   = s_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_lane    = s_lane_q;
    assign s_wr      = s_wr_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_ctrl
//   Directed and randomized transactions against sys_bus_ctrl with the
//   default slave map. Expected behaviour per transaction (target slave,
//   completion cycle, data, error, error log) comes from a table-driven
//   reference model of the address map and latency rules.
// ---------------------------------------------------------------------------
module tb_sys_bus_ctrl;

    localparam int          NS  = 4;
    localparam int          TO  = 255;
    localparam logic [31:0] DEF = 32'hFFFF_FFFF;
    localparam logic [7:0]  BASE_T [4] = '{8'h00, 8'h11, 8'h13, 8'h14};
    localparam logic [7:0]  MASK_T [4] = '{8'hF0, 8'hFF, 8'hFF, 8'hFF};
    localparam int          WAIT_T [4] = '{0, 15, 0, 0};

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       m_addr, m_wdata, m_rdata;
    logic [3:0]        m_lane;
    logic              m_wr, m_valid, m_ready, m_err;
    logic [NS-1:0]     s_valid, s_ready;
    logic [31:0]       s_addr, s_wdata;
    logic [3:0]        s_lane;
    logic              s_wr;
    logic [NS*32-1:0]  s_rdata;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_err_addr = 32'd0;
    int          exp_err_cnt = 0;
    bit          just_done = 1'b0;

    always #5 clk = ~clk;

    sys_bus_ctrl #(
        .NSLAVE       (4),
        .SLAVE_BASE   ({8'h14, 8'h13, 8'h11, 8'h00}),
        .SLAVE_MASK   ({8'hFF, 8'hFF, 8'hFF, 8'hF0}),
        .SLAVE_WAIT   ({4'd0, 4'd0, 4'hF, 4'd0}),
        .TIMEOUT      (TO),
        .DEFAULT_DATA (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_lane    (m_lane),
        .m_wr      (m_wr),
        .m_valid   (m_valid),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_lane    (s_lane),
        .s_wr      (s_wr),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: first window (lowest index) whose masked prefix matches.
    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a[31:24] & MASK_T[i]) == (BASE_T[i] & MASK_T[i])) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(7, 0))
            0, 1:    a[31:28] = 4'h0;
            2, 6:    a[31:24] = 8'h11;
            3:       a[31:24] = 8'h13;
            4:       a[31:24] = 8'h14;
            5:       a[31:24] = 8'h12;
            default: a[31:24] = a[31:24];
        endcase
        return a;
    endfunction

    task automatic drive_req(input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [3:0] lane);
        m_addr  = addr;
        m_wr    = wr;
        m_wdata = wdata;
        m_lane  = lane;
        m_valid = 1'b1;
    endtask

    // Master stays idle for n (>= 2) cycles, which also clears the post-DONE cycle.
    task automatic idle(input int n);
        m_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_ready", 32'(m_ready), 32'd0);
            chk("idle_s_valid", 32'(s_valid), 32'd0);
        end
        just_done = 1'b0;
    endtask

    // One transaction. hs_k: cycle of the access in which a handshake slave
    // raises s_ready (0 = never). late_switch: after a completion, the old
    // request is still shown for one more cycle before the new one.
    task automatic xact(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] lane, input logic [31:0] tgt_rdata, input int hs_k,
                        input bit drop_valid, input bit late_switch);
        int          idx;
        int          lat;
        logic        err;
        logic [31:0] rd_exp;
        logic [3:0]  sv_exp;
        logic [31:0] rdv [4];

        idx = decode(addr);
        for (int i = 0; i < 4; i++) rdv[i] = $urandom;
        if (idx >= 0) rdv[idx] = tgt_rdata;
        s_rdata = {rdv[3], rdv[2], rdv[1], rdv[0]};
        s_ready = 4'b0000;

        // Reference latency / outcome.
        if (idx < 0) begin
            lat = 1;
            err = 1'b1;
        end else if (WAIT_T[idx] == 15) begin
            if (hs_k >= 1 && hs_k <= TO) begin
                lat = hs_k + 1;
                err = 1'b0;
            end else begin
                lat = TO + 1;
                err = 1'b1;
            end
        end else begin
            lat = WAIT_T[idx] + 2;
            err = 1'b0;
        end
        rd_exp = err ? DEF : rdv[idx];
        sv_exp = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;

        // After a completion the controller spends one bubble cycle before
        // it will sample a request again.
        if (just_done) begin
            if (late_switch) m_valid = 1'b1;
            else drive_req(addr, wr, wdata, lane);
            tick();
            chk("bubble_ready", 32'(m_ready), 32'd0);
            chk("bubble_s_valid", 32'(s_valid), 32'd0);
            drive_req(addr, wr, wdata, lane);
            tick();
            chk("gap_ready", 32'(m_ready), 32'd0);
            chk("gap_s_valid", 32'(s_valid), 32'd0);
        end else begin
            drive_req(addr, wr, wdata, lane);
        end

        for (int c = 1; c <= lat; c++) begin
            tick();
            if (c == 1) begin
                if (drop_valid) begin
                    m_valid = 1'b0;
                    m_addr  = $urandom;
                end
                chk("s_addr", s_addr, addr);
                chk("s_wdata", s_wdata, wdata);
                chk("s_lane", 32'(s_lane), 32'(lane));
                chk("s_wr", 32'(s_wr), 32'(wr));
            end
            if (c < lat) begin
                chk("ready_early", 32'(m_ready), 32'd0);
                chk("s_valid", 32'(s_valid), 32'(sv_exp));
            end else begin
                if (err) begin
                    exp_err_addr = addr;
                    if (exp_err_cnt < 255) exp_err_cnt++;
                end
                chk("ready", 32'(m_ready), 32'd1);
                chk("err", 32'(m_err), 32'(err));
                if (!wr || err) chk("rdata", m_rdata, rd_exp);
                chk("s_valid_done", 32'(s_valid), 32'd0);
                chk("err_addr", err_addr, exp_err_addr);
                chk("err_count", 32'(err_count), 32'(exp_err_cnt));
            end
            s_ready = 4'b0000;
            if (idx >= 0 && WAIT_T[idx] == 15 && c == hs_k) s_ready[idx] = 1'b1;
        end
        s_ready   = 4'b0000;
        just_done = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_lane  = 4'd0;
        m_wr    = 1'b0;
        m_valid = 1'b0;
        s_rdata = '0;
        s_ready = 4'b0000;
        repeat (3) tick();

        // Reset state
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        idle(2);

        // Fixed slave 0, W=0
        xact(32'h0000_0010, 1'b0, 32'd0, 4'hF, 32'h1234_5678, 0, 1'b0, 1'b0);
        idle(2);
        // Handshake write, ready in the 3rd access cycle
        xact(32'h1100_0000, 1'b1, 32'hCAFE_F00D, 4'b0110, 32'h0BAD_0BAD, 3, 1'b0, 1'b0);
        idle(2);
        // Unmapped read
        xact(32'h2000_0000, 1'b0, 32'd0, 4'hF, 32'd0, 0, 1'b0, 1'b0);
        idle(2);
        // Handshake slave never ready: timeout
        xact(32'h1100_0004, 1'b0, 32'd0, 4'hF, 32'h5555_AAAA, 0, 1'b1, 1'b0);
        idle(2);
        // Ready in the timeout cycle itself: completes without error
        xact(32'h1100_0008, 1'b0, 32'd0, 4'hF, 32'h7777_8888, TO, 1'b0, 1'b0);
        // Back-to-back with the old request held over the bubble
        xact(32'h1300_0020, 1'b0, 32'd0, 4'hF, 32'h1357_9BDF, 0, 1'b0, 1'b1);
        xact(32'h1400_0030, 1'b0, 32'd0, 4'hF, 32'h2468_ACE0, 0, 1'b0, 1'b1);
        xact(32'h0F00_0040, 1'b1, 32'hDEAD_BEEF, 4'b1001, 32'h0, 0, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(8, 1);
            if ($urandom_range(24, 0) == 0) k = 0;
            xact(rand_addr(), 1'($urandom_range(1, 0)), $urandom, 4'($urandom), $urandom,
                 k, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(2, 0) == 0) idle($urandom_range(4, 2));
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            xact(32'h2000_0000 + 32'(n), 1'b0, 32'd0, 4'hF, 32'd0, 0, 1'b0, 1'b0);
        end
        chk("err_count_sat", 32'(err_count), 32'd255);
        idle(3);

        // Reset in the middle of an access
        s_ready = 4'b0000;
        drive_req(32'h1100_0100, 1'b0, 32'd0, 4'hF);
        tick();
        m_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_s_valid", 32'(s_valid), 32'h0000_0002);
        rst = 1'b1;
        tick();
        chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
        chk("mid_rst_ready", 32'(m_ready), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_err_addr", err_addr, 32'd0);
        chk("mid_rst_s_addr", s_addr, 32'd0);
        rst = 1'b0;
        exp_err_cnt  = 0;
        exp_err_addr = 32'd0;
        just_done    = 1'b0;
        xact(32'h1300_0040, 1'b0, 32'd0, 4'hF, 32'hA5A5_5A5A, 0, 1'b0, 1'b0);
        xact(32'h1100_0044, 1'b0, 32'd0, 4'hF, 32'h3C3C_C3C3, 2, 1'b0, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
